// File: rtl/button_conditioner.sv
// Synchronise, debounce and auto-repeat active-low pushbuttons; optional repeat via BUTTON_CONDITIONER_AUTOREPEAT_EN.
// Latency: press tick 2+DEBOUNCE_CYCLES cycles after first low sample; registered outputs, no backpressure.
module button_conditioner #(
  parameter int N_BTN           = 3,
  parameter int CNT_W           = 26,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 12_500_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] tick,
  output logic [N_BTN-1:0] pressed
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_C = CNT_W'(DEBOUNCE_CYCLES);
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_C = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RP_C = CNT_W'(REPEAT_PERIOD);
`endif

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             tick_q, tick_d;
    logic             pressed_q, pressed_d;
    logic             in_rel;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    logic             rep_q, rep_d;
    logic [CNT_W-1:0] target;
    assign target = rep_q ? RP_C : RD_C;
`endif

    assign in_rel  = sync2[i];
    assign cnt_inc = cnt_q + ONE;

    // Entering a wait state loads 1 rather than 0 so the entry cycle counts
    // toward DEBOUNCE_CYCLES; this gives the 2 + DEBOUNCE_CYCLES latency.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tick_d  = 1'b0;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
      rep_d   = rep_q;
`endif
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (!in_rel) begin
            if (ONE == DB_C) begin
              state_d = HELD;
              tick_d  = 1'b1;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
              rep_d   = 1'b0;
`endif
            end else begin
              state_d = PRESS_WAIT;
              cnt_d   = ONE;
            end
          end
        end
        PRESS_WAIT: begin
          if (in_rel) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_inc == DB_C) begin
            state_d = HELD;
            tick_d  = 1'b1;
            cnt_d   = '0;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
            rep_d   = 1'b0;
`endif
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HELD: begin
          if (in_rel) begin
            if (ONE == DB_C) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = REL_WAIT;
              cnt_d   = ONE;
            end
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
          end else if (cnt_inc == target) begin
            tick_d = 1'b1;
            cnt_d  = '0;
            rep_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
`else
          end else begin
            cnt_d = '0;
          end
`endif
        end
        REL_WAIT: begin
          if (!in_rel) begin
            state_d = HELD;
            cnt_d   = '0;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
            rep_d   = 1'b0;
`endif
          end else if (cnt_inc == DB_C) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
      pressed_d = (state_d == HELD) || (state_d == REL_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        tick_q    <= 1'b0;
        pressed_q <= 1'b0;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
        rep_q     <= 1'b0;
`endif
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        tick_q    <= tick_d;
        pressed_q <= pressed_d;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
        rep_q     <= rep_d;
`endif
      end
    end

    assign tick[i]    = tick_q;
    assign pressed[i] = pressed_q;
  end

endmodule
